load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- W, 32, data word width; only 32 is supported.
- AW, `ADDR_WIDTH, word-index width of the data memory.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, synchronous reset, active-high.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted when high together with req_valid at an edge.
- req_write, in, 1, 1 = store, 0 = load.
- req_addr, in, AW, word index.
- req_off, in, 2, byte offset within the word.
- req_size, in, 2, 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned, in, 1, zero-extend loads when 1; sign-extend when 0.
- req_wdata, in, W, store data, right-aligned.
- resp_valid, out, 1, response present.
- resp_ready, in, 1, response consumed when high together with resp_valid at an edge.
- resp_rdata, out, W, load result; 0 for stores and errors.
- resp_err, out, 1, misaligned or illegal request.
- mem_addr, out, AW, to the data memory address input.
- mem_write, out, 1, to the data memory write enable.
- mem_wdata, out, W, to the data memory write data.
- mem_rdata, in, W, from the data memory; registered and valid the cycle after an edge with mem_write=0.

Function
REQ-003 The FSM SHALL have states IDLE, RD, RD_DATA, WR, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE with rst low; requests SHALL be latched at acceptance and all later behaviour SHALL use the latched copy.
REQ-005 Little-endian byte lanes SHALL apply: byte k occupies bits [8k+7:8k].
REQ-006 Error condition: size 11, half with off[0]=1, or word with off≠00.
- IDLE→RESP with resp_err=1 and resp_rdata=0.
- No memory write SHALL occur for an error request.
REQ-007 Load path:
- IDLE→RD→RD_DATA→RESP.
- In RD, mem_addr=req_addr and mem_write=0.
- In RD_DATA, the selected lane(s) of mem_rdata SHALL be extended per req_unsigned and registered into resp_rdata.
REQ-008 Word store path:
- IDLE→WR→RESP.
- In WR, mem_write=1 and mem_wdata=req_wdata.
REQ-009 Byte/half store path (read-modify-write):
- IDLE→RD→RD_DATA→WR→RESP.
- In RD_DATA, the target lane(s) of mem_rdata SHALL be replaced with the low 8 or 16 bits of req_wdata; all other lanes SHALL be preserved.
REQ-010 mem_write SHALL be 1 only in WR with rst low, for exactly one cycle per store; it SHALL be 0 in all other states.
REQ-011 mem_addr SHALL equal the latched req_addr from acceptance until return to IDLE; it SHALL hold its value in IDLE.
REQ-012 In RESP, resp_valid SHALL be 1 and resp_rdata and resp_err SHALL be stable until the handshake edge; the FSM then enters IDLE.
REQ-013 A new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-014 Latency from acceptance edge to first resp_valid cycle:
- load: 3 cycles.
- word store: 2 cycles.
- sub-word store: 4 cycles.
- error: 1 cycle.

Reset
REQ-015 At a rising edge with rst=1:
- state SHALL become IDLE.
- resp_valid, resp_err, mem_write SHALL be 0.
- resp_rdata, mem_addr, mem_wdata SHALL be 0.
- Any in-flight request SHALL be discarded.
REQ-016 rst=1 in WR SHALL suppress the write at that edge: mem_write is gated by rst.

Verification
REQ-017 Word store then load: store addr=5, wdata=0xDEADBEEF, then load word addr=5 → resp_rdata=0xDEADBEEF, resp_err=0, store latency 2, load latency 3.
REQ-018 Byte RMW: mem[3]=0x11223344; store byte off=2 wdata=0xAB → mem[3]=0x11AB3344. Load byte off=2 signed → 0xFFFFFFAB; unsigned → 0x000000AB.
REQ-019 Half load: mem[7]=0x8001F00F; off=2 signed → 0xFFFF8001; off=0 unsigned → 0x0000F00F.
REQ-020 Errors: word off=01, half off=11, size=11 → resp_err=1, resp_rdata=0, mem_write never 1, latency 1.
REQ-021 Backpressure: hold resp_ready=0 for 5 cycles → resp_valid and data stable, req_ready=0; req_ready=1 the cycle after the handshake.
REQ-022 Reset in WR of an RMW to addr=2 (mem[2]=0x0) → mem[2] stays 0x0, all outputs 0, req_ready=1 the cycle after the reset edge.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores against a single-port data memory
//   with registered read data; sub-word stores are read-modify-write.
// Latency (acceptance edge to first resp_valid): error 1, word store 2, load 3, sub-word store 4.
// Backpressure: one request in flight; req_ready is low until the response handshake completes,
//   and resp_valid/resp_rdata/resp_err hold while resp_ready is low.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_*             - request channel (valid/ready), latched at acceptance
//   resp_*            - response channel (valid/ready): load data and error flag
//   mem_*             - data memory: word address, write enable, write data, read data
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module load_store_unit #(
  parameter int W  = 32,
  parameter int AW = `ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_off,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [W-1:0]  req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [W-1:0]  resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, RD_DATA, WR, RESP} state_t;

  state_t        state_q, state_d;
  logic          write_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [W-1:0]  wdata_q;   // store data; replaced by the merged word during RMW
  logic [W-1:0]  rdata_q;
  logic          err_q;

  logic          req_err;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [W-1:0]  load_val;
  logic [W-1:0]  merge_val;

  // Misaligned or illegal sizes are decided on the live request at acceptance.
  assign req_err = (req_size == SZ_ILL) ||
                   ((req_size == SZ_HALF) && req_off[0]) ||
                   ((req_size == SZ_WORD) && (req_off != 2'b00));

  assign req_ready  = (state_q == IDLE) && !rst;
  assign mem_write  = (state_q == WR) && !rst;   // a reset edge in WR must not commit the write
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    byte_sel  = mem_rdata[{off_q, 3'b000} +: 8];
    half_sel  = mem_rdata[{off_q[1], 4'b0000} +: 16];
    load_val  = mem_rdata;
    merge_val = mem_rdata;
    case (size_q)
      SZ_BYTE: begin
        load_val = uns_q ? {{(W-8){1'b0}}, byte_sel} : {{(W-8){byte_sel[7]}}, byte_sel};
        merge_val[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_val = uns_q ? {{(W-16){1'b0}}, half_sel} : {{(W-16){half_sel[15]}}, half_sel};
        merge_val[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                              state_d = RESP;
          else if (req_write && req_size == SZ_WORD) state_d = WR;
          else                                      state_d = RD;
        end
      end
      RD:      state_d = RD_DATA;
      RD_DATA: state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        off_q   <= req_off;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        rdata_q <= '0;          // stores and errors respond with zero data
        err_q   <= req_err;
      end
      if (state_q == RD_DATA) begin
        if (write_q) wdata_q <= merge_val;
        else         rdata_q <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a registered-read memory model.
// Latency: n/a (bench).
// Backpressure: resp_ready held low for a chosen number of cycles per transaction.
module tb_load_store_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write, req_unsigned;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_off, req_size;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.W(32), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_off(req_off), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Data memory: write on mem_write, otherwise registered read of mem_addr.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;
  int            wr_count = 0;

  always @(posedge clk) begin
    if (bd_we)          mem[bd_addr] <= bd_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
    if (!mem_write) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) if (mem_write === 1'b1) wr_count <= wr_count + 1;

  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [1:0]    off;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          checks = 0;
  int          failures = 0;

  // Reference behaviour written with shifts and masks.
  function automatic exp_t model(input req_t r, input logic [31:0] word);
    exp_t        e;
    logic [31:0] v;
    int          sh;
    sh = 8 * int'(r.off);
    e.err = !((r.size == 2'd0) || (r.size == 2'd1 && r.off[0] == 1'b0) ||
              (r.size == 2'd2 && r.off == 2'd0));
    v = 32'h0;
    if (!e.err && !r.w) begin
      if (r.size == 2'd0) begin
        v = (word >> sh) & 32'hFF;
        if (!r.uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (r.size == 2'd1) begin
        v = (word >> sh) & 32'hFFFF;
        if (!r.uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = word;
      end
    end
    e.rdata = v;
    if (e.err)               e.lat = 1;
    else if (!r.w)           e.lat = 3;
    else if (r.size == 2'd2) e.lat = 2;
    else                     e.lat = 4;
    return e;
  endfunction

  function automatic logic [31:0] merged(input req_t r, input logic [31:0] word);
    logic [31:0] mask;
    int          sh;
    sh = 8 * int'(r.off);
    if (r.size == 2'd2) return r.wdata;
    mask = ((r.size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (word & ~mask) | ((r.wdata << sh) & mask);
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Drives one request, waits for its response, holds resp_ready low for 'hold' cycles.
  task automatic send_req(input req_t r, input int hold,
                          output logic [31:0] rd, output logic er, output int lat,
                          output bit stable, output logic rdy_at_hs, output logic rdy_after,
                          output bit tmo);
    int n;
    rd = 'x; er = 1'bx; lat = 0; stable = 1'b1; rdy_at_hs = 1'bx; rdy_after = 1'bx; tmo = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = r.w; req_addr = r.addr; req_off = r.off;
    req_size = r.size; req_unsigned = r.uns; req_wdata = r.wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) begin tmo = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk);
    #1;
    // Scramble the request bus: the unit must work from its latched copy.
    req_valid = 1'b0; req_write = ~r.w; req_addr = ~r.addr; req_off = ~r.off;
    req_unsigned = ~r.uns; req_wdata = ~r.wdata;
    lat = 1;
    @(negedge clk);
    while (resp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    if (resp_valid !== 1'b1) begin tmo = 1'b1; return; end
    rd = resp_rdata; er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0)
        stable = 1'b0;
    end
    resp_ready = 1'b1;
    rdy_at_hs = req_ready;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    rdy_after = req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_off = '0;
    req_size = '0; req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, mem_write, req_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got valid/err/write/ready=%b%b%b%b, want 0000",
               resp_valid, resp_err, mem_write, req_ready);
    end
    checks++;
    if (resp_rdata !== 32'h0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, want all 0",
               resp_rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got req_ready=%b, want 1", req_ready);
    end
  endtask

  task automatic test_word_store_load();
    req_t t[2];
    exp_t e;
    logic [31:0] rd; logic er, ha, hb; int lat, w0; bit st, tmo;
    t[0] = '{1'b1, 8'd5, 2'd0, 2'd2, 1'b0, 32'hDEAD_BEEF};
    t[1] = '{1'b0, 8'd5, 2'd0, 2'd2, 1'b0, 32'h0};
    sb.push_back('{32'h0, 1'b0, 2});
    sb.push_back('{32'hDEAD_BEEF, 1'b0, 3});
    w0 = wr_count;
    for (int i = 0; i < 2; i++) begin
      send_req(t[i], 0, rd, er, lat, st, ha, hb, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || rd !== e.rdata || er !== e.err || lat != e.lat) begin
        failures++;
        $display("FAIL word_store_load[%0d]: got rdata=%h err=%b lat=%0d tmo=%0b, want rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, tmo, e.rdata, e.err, e.lat);
      end
    end
    checks++;
    if (wr_count - w0 != 1) begin
      failures++;
      $display("FAIL word_store_writes: got %0d write cycles, want 1", wr_count - w0);
    end
  endtask

  task automatic test_byte_rmw();
    req_t t[3];
    exp_t e;
    logic [31:0] rd; logic er, ha, hb; int lat, w0; bit st, tmo;
    preload(8'd3, 32'h1122_3344);
    t[0] = '{1'b1, 8'd3, 2'd2, 2'd0, 1'b0, 32'h1234_56AB};
    t[1] = '{1'b0, 8'd3, 2'd2, 2'd0, 1'b0, 32'h0};
    t[2] = '{1'b0, 8'd3, 2'd2, 2'd0, 1'b1, 32'h0};
    sb.push_back('{32'h0, 1'b0, 4});
    sb.push_back('{32'hFFFF_FFAB, 1'b0, 3});
    sb.push_back('{32'h0000_00AB, 1'b0, 3});
    w0 = wr_count;
    for (int i = 0; i < 3; i++) begin
      send_req(t[i], 0, rd, er, lat, st, ha, hb, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || rd !== e.rdata || er !== e.err || lat != e.lat) begin
        failures++;
        $display("FAIL byte_rmw[%0d]: got rdata=%h err=%b lat=%0d tmo=%0b, want rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, tmo, e.rdata, e.err, e.lat);
      end
      if (i == 0) begin
        checks++;
        if (mem[3] !== 32'h11AB_3344 || wr_count - w0 != 1) begin
          failures++;
          $display("FAIL byte_rmw_mem: got mem[3]=%h writes=%0d, want 11ab3344 writes=1",
                   mem[3], wr_count - w0);
        end
      end
    end
  endtask

  task automatic test_half_load();
    req_t t[4];
    exp_t e;
    logic [31:0] rd; logic er, ha, hb; int lat; bit st, tmo;
    preload(8'd7, 32'h8001_F00F);
    t[0] = '{1'b0, 8'd7, 2'd2, 2'd1, 1'b0, 32'h0};
    t[1] = '{1'b0, 8'd7, 2'd0, 2'd1, 1'b1, 32'h0};
    t[2] = '{1'b0, 8'd7, 2'd0, 2'd1, 1'b0, 32'h0};
    t[3] = '{1'b0, 8'd7, 2'd3, 2'd0, 1'b1, 32'h0};
    sb.push_back('{32'hFFFF_8001, 1'b0, 3});
    sb.push_back('{32'h0000_F00F, 1'b0, 3});
    sb.push_back('{32'hFFFF_F00F, 1'b0, 3});
    sb.push_back('{32'h0000_0080, 1'b0, 3});
    for (int i = 0; i < 4; i++) begin
      send_req(t[i], 0, rd, er, lat, st, ha, hb, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || rd !== e.rdata || er !== e.err || lat != e.lat) begin
        failures++;
        $display("FAIL half_load[%0d]: got rdata=%h err=%b lat=%0d tmo=%0b, want rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, tmo, e.rdata, e.err, e.lat);
      end
    end
  endtask

  task automatic test_errors();
    req_t t[4];
    exp_t e;
    logic [31:0] rd; logic er, ha, hb; int lat, w0; bit st, tmo;
    t[0] = '{1'b1, 8'd7, 2'd1, 2'd2, 1'b0, 32'h5555_AAAA};
    t[1] = '{1'b1, 8'd7, 2'd3, 2'd1, 1'b0, 32'h5555_AAAA};
    t[2] = '{1'b1, 8'd7, 2'd0, 2'd3, 1'b0, 32'h5555_AAAA};
    t[3] = '{1'b0, 8'd7, 2'd2, 2'd2, 1'b1, 32'h0};
    for (int i = 0; i < 4; i++) sb.push_back('{32'h0, 1'b1, 1});
    w0 = wr_count;
    for (int i = 0; i < 4; i++) begin
      send_req(t[i], 0, rd, er, lat, st, ha, hb, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || rd !== e.rdata || er !== e.err || lat != e.lat) begin
        failures++;
        $display("FAIL errors[%0d]: got rdata=%h err=%b lat=%0d tmo=%0b, want rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, tmo, e.rdata, e.err, e.lat);
      end
    end
    checks++;
    if (wr_count != w0 || mem[7] !== 32'h8001_F00F) begin
      failures++;
      $display("FAIL errors_no_write: got writes=%0d mem[7]=%h, want writes=0 mem[7]=8001f00f",
               wr_count - w0, mem[7]);
    end
  endtask

  task automatic test_backpressure();
    req_t r;
    exp_t e;
    logic [31:0] rd; logic er, ha, hb; int lat; bit st, tmo;
    preload(8'd9, 32'hCAFE_F00D);
    r = '{1'b0, 8'd9, 2'd0, 2'd2, 1'b0, 32'h0};
    sb.push_back('{32'hCAFE_F00D, 1'b0, 3});
    send_req(r, 5, rd, er, lat, st, ha, hb, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || rd !== e.rdata || er !== e.err || lat != e.lat) begin
      failures++;
      $display("FAIL bp_data: got rdata=%h err=%b lat=%0d tmo=%0b, want rdata=%h err=%b lat=%0d",
               rd, er, lat, tmo, e.rdata, e.err, e.lat);
    end
    checks++;
    if (st !== 1'b1) begin
      failures++;
      $display("FAIL bp_stable: got stable=%0b, want 1", st);
    end
    checks++;
    if (ha !== 1'b0 || hb !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready: got ready at handshake=%b after=%b, want 0 and 1", ha, hb);
    end
  endtask

  task automatic test_reset_in_wr();
    req_t r;
    exp_t e;
    logic [31:0] rd; logic er, ha, hb; int lat, w0, n; bit st, tmo;
    preload(8'd2, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd2; req_off = 2'd1;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0000_005A;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    w0 = wr_count;
    @(negedge clk);
    n = 0;
    while (mem_write !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (mem_write !== 1'b1) begin
      failures++;
      $display("FAIL rst_wr_reach: got mem_write=%b, want 1 within bound", mem_write);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem[2] !== 32'h0 || wr_count != w0) begin
      failures++;
      $display("FAIL rst_wr_mem: got mem[2]=%h writes=%0d, want 0 and 0", mem[2], wr_count - w0);
    end
    checks++;
    if ({resp_valid, resp_err, mem_write, req_ready} !== 4'b0000 || resp_rdata !== 32'h0 ||
        mem_addr !== '0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_wr_outputs: got v/e/w/r=%b%b%b%b rdata=%h addr=%h wdata=%h, want all 0",
               resp_valid, resp_err, mem_write, req_ready, resp_rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_wr_ready: got req_ready=%b, want 1", req_ready);
    end
    r = '{1'b0, 8'd2, 2'd0, 2'd2, 1'b0, 32'h0};
    sb.push_back('{32'h0, 1'b0, 3});
    send_req(r, 0, rd, er, lat, st, ha, hb, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || rd !== e.rdata || er !== e.err || lat != e.lat) begin
      failures++;
      $display("FAIL rst_wr_reload: got rdata=%h err=%b lat=%0d tmo=%0b, want rdata=%h err=%b lat=%0d",
               rd, er, lat, tmo, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_random();
    req_t r;
    exp_t e;
    logic [31:0] rd; logic er, ha, hb; int lat; bit st, tmo;
    for (int a = 16; a < 20; a++) preload(AW'(a), $urandom);
    for (int i = 0; i < 16; i++) begin
      r.w     = 1'($urandom_range(0, 1));
      r.addr  = AW'($urandom_range(16, 19));
      r.size  = 2'($urandom_range(0, 2));
      r.off   = (r.size == 2'd2) ? 2'd0 :
                (r.size == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'($urandom_range(0, 3));
      r.uns   = 1'($urandom_range(0, 1));
      r.wdata = $urandom;
      sb.push_back(model(r, ref_mem[r.addr]));
      if (r.w) ref_mem[r.addr] = merged(r, ref_mem[r.addr]);
      send_req(r, int'($urandom_range(0, 2)), rd, er, lat, st, ha, hb, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || rd !== e.rdata || er !== e.err || lat != e.lat) begin
        failures++;
        $display("FAIL random[%0d]: got rdata=%h err=%b lat=%0d tmo=%0b, want rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, tmo, e.rdata, e.err, e.lat);
      end
    end
    for (int a = 16; a < 20; a++) begin
      checks++;
      if (mem[a] !== ref_mem[a]) begin
        failures++;
        $display("FAIL random_mem[%0d]: got %h, want %h", a, mem[a], ref_mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_half_load();
    test_errors();
    test_backpressure();
    test_reset_in_wr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
